// File: rtl/button_input_pkg.sv
// Shared types and constants for the button_input debouncer.
package button_input_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_t;

endpackage

// File: rtl/button_debounce_fsm.sv
// Per-button debounce FSM: stable-sample counting, event pulses, press counter
// and (with BUTTON_INPUT_LONG_PRESS_EN) the long-press hold counter.
module button_debounce_fsm
  import button_input_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = 20,
  parameter int unsigned LONG_TICKS   = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             raw,
  output logic             level,
  output logic             press_evt,
  output logic             release_evt,
  output logic [CNT_W-1:0] press_cnt
`ifdef BUTTON_INPUT_LONG_PRESS_EN
  ,
  output logic             long_evt
`endif
);

  localparam int unsigned SW = $clog2(STABLE_TICKS + 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_TICKS);

  btn_state_t    state_q, state_n;
  logic [SW-1:0] cnt_q, cnt_n, cnt_inc;
  logic          press_n, release_n;

  assign cnt_inc = cnt_q + SW'(1);

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    press_n   = 1'b0;
    release_n = 1'b0;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (raw) begin
            state_n = PRESS_WAIT;
            cnt_n   = SW'(1);
          end
        end
        PRESS_WAIT: begin
          if (!raw) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else if (cnt_inc == STABLE_MAX) begin
            state_n = PRESSED;
            cnt_n   = '0;
            press_n = 1'b1;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        PRESSED: begin
          if (!raw) begin
            state_n = RELEASE_WAIT;
            cnt_n   = SW'(1);
          end
        end
        RELEASE_WAIT: begin
          if (raw) begin
            state_n = PRESSED;
            cnt_n   = '0;
          end else if (cnt_inc == STABLE_MAX) begin
            state_n   = IDLE;
            cnt_n     = '0;
            release_n = 1'b1;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      level       <= 1'b0;
      press_evt   <= 1'b0;
      release_evt <= 1'b0;
      press_cnt   <= '0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      level       <= (state_n == PRESSED) || (state_n == RELEASE_WAIT);
      press_evt   <= press_n;
      release_evt <= release_n;
      if (press_n) press_cnt <= press_cnt + CNT_W'(1);
    end
  end

`ifdef BUTTON_INPUT_LONG_PRESS_EN
  localparam int unsigned LW = $clog2(LONG_TICKS + 1);
  localparam logic [LW-1:0] LONG_MAX = LW'(LONG_TICKS);

  logic [LW-1:0] hold_q, hold_n, hold_inc;
  logic          long_n;

  assign hold_inc = hold_q + LW'(1);

  // Saturating at LONG_MAX is what limits btn_long to one pulse per press,
  // even across release bounces that return to PRESSED.
  always_comb begin
    hold_n = hold_q;
    long_n = 1'b0;
    if (tick && state_q == PRESSED && raw && hold_q != LONG_MAX) begin
      hold_n = hold_inc;
      long_n = (hold_inc == LONG_MAX);
    end
    if (state_n == IDLE) hold_n = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q   <= '0;
      long_evt <= 1'b0;
    end else begin
      hold_q   <= hold_n;
      long_evt <= long_n;
    end
  end
`else
  localparam int unsigned LONG_UNUSED = LONG_TICKS;
`endif

endmodule

// File: rtl/button_input.sv
// Multi-button debouncer: synchronizers and shared tick prescaler feeding one
// button_debounce_fsm per button. Define BUTTON_INPUT_LONG_PRESS_EN for btn_long.
module button_input
  import button_input_pkg::*;
#(
  parameter int unsigned NUM_BTN      = 2,
  parameter int unsigned TICK_DIV     = 27000,
  parameter int unsigned STABLE_TICKS = 20,
  parameter int unsigned LONG_TICKS   = 1000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_BTN-1:0]         btn_n,
  output logic [NUM_BTN-1:0]         btn_level,
  output logic [NUM_BTN-1:0]         btn_press,
  output logic [NUM_BTN-1:0]         btn_release,
  output logic [CNT_W*NUM_BTN-1:0]   press_cnt
`ifdef BUTTON_INPUT_LONG_PRESS_EN
  ,
  output logic [NUM_BTN-1:0]         btn_long
`endif
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] DIV_LAST = PW'(TICK_DIV - 1);

  logic [NUM_BTN-1:0] sync1, sync2, raw;
  logic [PW-1:0]      div_q;
  logic               tick;

  // Synchronizers reset to the released level so a button held through
  // reset is seen as a fresh press afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  assign raw = ~sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      tick  <= 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
      tick  <= 1'b1;
    end else begin
      div_q <= div_q + PW'(1);
      tick  <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
`ifdef BUTTON_INPUT_LONG_PRESS_EN
    button_debounce_fsm #(
      .STABLE_TICKS(STABLE_TICKS),
      .LONG_TICKS  (LONG_TICKS)
    ) u_fsm (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .raw        (raw[i]),
      .level      (btn_level[i]),
      .press_evt  (btn_press[i]),
      .release_evt(btn_release[i]),
      .press_cnt  (press_cnt[CNT_W*i +: CNT_W]),
      .long_evt   (btn_long[i])
    );
`else
    button_debounce_fsm #(
      .STABLE_TICKS(STABLE_TICKS),
      .LONG_TICKS  (LONG_TICKS)
    ) u_fsm (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .raw        (raw[i]),
      .level      (btn_level[i]),
      .press_evt  (btn_press[i]),
      .release_evt(btn_release[i]),
      .press_cnt  (press_cnt[CNT_W*i +: CNT_W])
    );
`endif
  end

endmodule

// File: tb/tb_button_input.sv
// Directed bench for button_input with TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=8.
module tb_button_input;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  btn_n = 2'b11;
  logic [1:0]  btn_level, btn_press, btn_release;
  logic [15:0] press_cnt;
`ifdef BUTTON_INPUT_LONG_PRESS_EN
  logic [1:0]  btn_long;
`endif

  button_input #(
    .NUM_BTN     (2),
    .TICK_DIV    (4),
    .STABLE_TICKS(3),
    .LONG_TICKS  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_n      (btn_n),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .press_cnt  (press_cnt)
`ifdef BUTTON_INPUT_LONG_PRESS_EN
    ,
    .btn_long   (btn_long)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Cumulative pulse counters, sampled on the falling edge.
  int press_tot[2];
  int rel_tot[2];
  int long_tot[2];
  int both_evt   = 0;
  int dual_press = 0;

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (btn_press[i]) press_tot[i]++;
        if (btn_release[i]) rel_tot[i]++;
        if (btn_press[i] && btn_release[i]) both_evt++;
`ifdef BUTTON_INPUT_LONG_PRESS_EN
        if (btn_long[i]) long_tot[i]++;
`endif
      end
      if (btn_press == 2'b11) dual_press++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    clocks(n);
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic [1:0]  btn_n;
    logic [7:0]  clks;
    logic [1:0]  lvl;
    logic [1:0]  prs;
    logic [1:0]  rel;
    logic [1:0]  lng;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[8];
  int   bp[2], br[2], bl[2], bdual;
  bit   found;

  task automatic snap();
    for (int i = 0; i < 2; i++) begin
      bp[i] = press_tot[i];
      br[i] = rel_tot[i];
      bl[i] = long_tot[i];
    end
    bdual = dual_press;
  endtask

  initial begin
    vecs[0] = '{btn_n: 2'b10, clks: 8'd8,  lvl: 2'b00, prs: 2'b00, rel: 2'b00, lng: 2'b00, cnt: 16'h0000};
    vecs[1] = '{btn_n: 2'b11, clks: 8'd40, lvl: 2'b00, prs: 2'b00, rel: 2'b00, lng: 2'b00, cnt: 16'h0000};
    vecs[2] = '{btn_n: 2'b10, clks: 8'd80, lvl: 2'b01, prs: 2'b01, rel: 2'b00, lng: 2'b01, cnt: 16'h0001};
    vecs[3] = '{btn_n: 2'b11, clks: 8'd40, lvl: 2'b00, prs: 2'b00, rel: 2'b01, lng: 2'b00, cnt: 16'h0001};
    vecs[4] = '{btn_n: 2'b01, clks: 8'd80, lvl: 2'b10, prs: 2'b10, rel: 2'b00, lng: 2'b10, cnt: 16'h0101};
    vecs[5] = '{btn_n: 2'b11, clks: 8'd40, lvl: 2'b00, prs: 2'b00, rel: 2'b10, lng: 2'b00, cnt: 16'h0101};
    vecs[6] = '{btn_n: 2'b00, clks: 8'd80, lvl: 2'b11, prs: 2'b11, rel: 2'b00, lng: 2'b11, cnt: 16'h0202};
    vecs[7] = '{btn_n: 2'b11, clks: 8'd40, lvl: 2'b00, prs: 2'b00, rel: 2'b11, lng: 2'b00, cnt: 16'h0202};

    // Buttons held through reset: outputs quiet, then a fresh press on both.
    btn_n = 2'b00;
    do_reset(3);
    check("rst_level",   {30'd0, btn_level},   32'd0);
    check("rst_press",   {30'd0, btn_press},   32'd0);
    check("rst_release", {30'd0, btn_release}, 32'd0);
    check("rst_cnt",     {16'd0, press_cnt},   32'd0);
    found = 1'b0;
    for (int k = 0; k < 18 && !found; k++) begin
      clocks(1);
      if (btn_press == 2'b11) found = 1'b1;
    end
    check("held_through_reset_press", {31'd0, found}, 32'd1);

    // Reset mid-press clears the count.
    btn_n = 2'b11;
    do_reset(2);
    check("rst_clear_cnt",   {16'd0, press_cnt}, 32'd0);
    check("rst_clear_level", {30'd0, btn_level}, 32'd0);
    clocks(10);

    for (int v = 0; v < 8; v++) begin
      snap();
      btn_n = vecs[v].btn_n;
      clocks(int'(vecs[v].clks));
      check($sformatf("v%0d_level", v), {30'd0, btn_level}, {30'd0, vecs[v].lvl});
      check($sformatf("v%0d_cnt", v),   {16'd0, press_cnt}, {16'd0, vecs[v].cnt});
      for (int i = 0; i < 2; i++) begin
        check($sformatf("v%0d_press%0d", v, i),   press_tot[i] - bp[i], {31'd0, vecs[v].prs[i]});
        check($sformatf("v%0d_release%0d", v, i), rel_tot[i] - br[i],   {31'd0, vecs[v].rel[i]});
`ifdef BUTTON_INPUT_LONG_PRESS_EN
        check($sformatf("v%0d_long%0d", v, i),    long_tot[i] - bl[i],  {31'd0, vecs[v].lng[i]});
`endif
      end
    end

    // 256 clean presses on button 1 wrap its counter back to 0.
    do_reset(2);
    snap();
    for (int n = 0; n < 256; n++) begin
      btn_n = 2'b01;
      clocks(24);
      btn_n = 2'b11;
      clocks(24);
    end
    check("wrap_press_pulses",   press_tot[1] - bp[1], 32'd256);
    check("wrap_release_pulses", rel_tot[1] - br[1],   32'd256);
    check("wrap_cnt1",           {24'd0, press_cnt[15:8]}, 32'd0);
    check("wrap_cnt0",           {24'd0, press_cnt[7:0]},  32'd0);

    // Simultaneous press, then a one-tick release bounce inside RELEASE_WAIT.
    do_reset(2);
    snap();
    btn_n = 2'b00;
    clocks(40);
    check("dual_press_same_cycle", dual_press - bdual, 32'd1);
    check("dual_level",            {30'd0, btn_level}, 32'd3);
    btn_n = 2'b11;
    clocks(4);
    btn_n = 2'b00;
    clocks(24);
    check("bounce_no_release0", rel_tot[0] - br[0],  32'd0);
    check("bounce_no_release1", rel_tot[1] - br[1],  32'd0);
    check("bounce_level",       {30'd0, btn_level},  32'd3);
    btn_n = 2'b11;
    clocks(40);
    check("final_release0", rel_tot[0] - br[0], 32'd1);
    check("final_release1", rel_tot[1] - br[1], 32'd1);
    check("final_level",    {30'd0, btn_level}, 32'd0);
    check("final_cnt",      {16'd0, press_cnt}, 32'h0101);
    check("press_release_same_cycle", both_evt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
